// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: mult/multu/div/divu into HI/LO,
// plus mthi/mtlo writes, with a pipeline stall while an operation is in flight.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] RS_In,
    input  logic [WIDTH-1:0] RT_In,
    input  logic             WriteHI,
    input  logic             WriteLO,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] HI_Out,
    output logic [WIDTH-1:0] LO_Out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] rs_raw_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;

    // Operand preparation: signed ops work on magnitudes and fix the sign at the end.
    logic             signed_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    always_comb begin
        signed_op = ~Op[0];
        rs_neg    = signed_op & RS_In[WIDTH-1];
        rt_neg    = signed_op & RT_In[WIDTH-1];
        rs_mag    = rs_neg ? -RS_In : RS_In;
        rt_mag    = rt_neg ? -RT_In : RT_In;
    end

    // One iteration: mul keeps {acc_hi,acc_lo} as a shifting product whose low half starts
    // as the multiplier; div keeps remainder in acc_hi and shifts quotient bits into acc_lo.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
        div_diff = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, a_q};
        if (op_q[1]) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
        if (!op_q[1]) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
            // Divide by zero leaves the dividend in HI and saturates the quotient.
            fix_hi = rs_raw_q;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rs_raw_q   <= '0;
            a_q        <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start && !Flush) begin
                        op_q       <= Op;
                        a_q        <= Op[1] ? rt_mag : rs_mag;
                        acc_hi_q   <= '0;
                        acc_lo_q   <= Op[1] ? rs_mag : rt_mag;
                        neg_res_q  <= rs_neg ^ rt_neg;
                        neg_rem_q  <= rs_neg;
                        div_zero_q <= (RT_In == '0);
                        rs_raw_q   <= RS_In;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else if (!Flush) begin
                        if (WriteHI) hi_q <= RS_In;
                        if (WriteLO) lo_q <= RS_In;
                    end
                end
                RUN: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST_STEP) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake: Start/WriteHI/WriteLO/ReadHiLo are valids from ID/EX and the unit is ready
    // whenever it is not Busy; a valid seen while Busy raises Stall and upstream must hold it.
    assign Stall  = busy_q & (Start | ReadHiLo | WriteHI | WriteLO);
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign HI_Out = hi_q;
    assign LO_Out = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random ops against an
// arithmetic reference model, with results matched by a Done-driven scoreboard.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         Clock;
    logic         Reset;
    logic         Flush;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] RS_In;
    logic [W-1:0] RT_In;
    logic         WriteHI;
    logic         WriteLO;
    logic         ReadHiLo;
    logic         Busy;
    logic         Done;
    logic         Stall;
    logic [W-1:0] HI_Out;
    logic [W-1:0] LO_Out;

    int tests = 0;
    int fails = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] pend;
    logic [2*W-1:0] mon_exp;
    logic [W-1:0]   model_hi;
    logic [W-1:0]   model_lo;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Flush   (Flush),
        .Start   (Start),
        .Op      (Op),
        .RS_In   (RS_In),
        .RT_In   (RT_In),
        .WriteHI (WriteHI),
        .WriteLO (WriteLO),
        .ReadHiLo(ReadHiLo),
        .Busy    (Busy),
        .Done    (Done),
        .Stall   (Stall),
        .HI_Out  (HI_Out),
        .LO_Out  (LO_Out)
    );

    // Clock and reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain integer arithmetic, result packed as {HI, LO}
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur, res;
        sa  = longint'($signed(rs));
        sb  = longint'($signed(rt));
        ua  = {32'b0, rs};
        ub  = {32'b0, rt};
        res = '0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (rt == 32'b0) begin
                    res = {rs, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end else begin
                    uq  = ua / ub;
                    ur  = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard monitor: every Done pulse consumes one expected {HI, LO}
    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at %0t: got HI=%0h LO=%0h with no pending op",
                         $time, HI_Out, LO_Out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard_hilo", 128'({HI_Out, LO_Out}), 128'(mon_exp));
            end
        end
    end

    // Driver tasks (all called right after a falling edge)
    task automatic issue(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
        Op    = op;
        RS_In = rs;
        RT_In = rt;
        Flush = 1'b0;
        Start = 1'b1;
        pend  = ref_model(op, rs, rt);
        exp_q.push_back(pend);
    endtask

    // Follows one op for W+2 cycles; Done is required exactly in the last one.
    task automatic wait_op(input bit rand_read, input bit keep_start, input logic [1:0] op2,
                           input logic [W-1:0] rs2, input logic [W-1:0] rt2);
        logic stall_e;
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge Clock);
            if (cyc < W + 2) begin
                stall_e = Start | ReadHiLo | WriteHI | WriteLO;
                check("busy_cycle", 128'({Busy, Done, Stall, HI_Out, LO_Out}),
                      128'({1'b1, 1'b0, stall_e, model_hi, model_lo}));
            end else begin
                {model_hi, model_lo} = pend;
                check("done_cycle", 128'({Busy, Done, Stall, HI_Out, LO_Out}),
                      128'({1'b0, 1'b1, 1'b0, model_hi, model_lo}));
            end
            WriteHI = 1'b0;
            WriteLO = 1'b0;
            if (cyc < W + 2) begin
                if (keep_start) begin
                    Start    = 1'b1;
                    Op       = op2;
                    RS_In    = rs2;
                    RT_In    = rt2;
                    ReadHiLo = 1'b1;
                end else begin
                    Start    = 1'b0;
                    ReadHiLo = rand_read ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end else begin
                ReadHiLo = 1'b0;
                if (keep_start) begin
                    // The held Start is taken at the next edge now that the unit is idle.
                    pend = ref_model(op2, rs2, rt2);
                    exp_q.push_back(pend);
                end else begin
                    Start = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            check("idle_cycle", 128'({Busy, Done, Stall, HI_Out, LO_Out}),
                  128'({1'b0, 1'b0, 1'b0, model_hi, model_lo}));
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t dir_tab[10];

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_rs;
        logic [W-1:0] r_rt;

        dir_tab[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        dir_tab[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        dir_tab[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        dir_tab[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        dir_tab[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        dir_tab[5] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        dir_tab[6] = '{2'b11, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFF};
        dir_tab[7] = '{2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
        dir_tab[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        dir_tab[9] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        Reset    = 1'b1;
        Flush    = 1'b0;
        Start    = 1'b0;
        Op       = 2'b00;
        RS_In    = '0;
        RT_In    = '0;
        WriteHI  = 1'b0;
        WriteLO  = 1'b0;
        ReadHiLo = 1'b0;
        model_hi = '0;
        model_lo = '0;

        repeat (2) @(negedge Clock);
        check("reset_state", 128'({Busy, Done, Stall, HI_Out, LO_Out}), 128'(0));
        Reset = 1'b0;
        idle_check(2);

        // mthi alone, then mtlo+mthi together
        WriteHI = 1'b1;
        RS_In   = 32'h0000_1234;
        @(negedge Clock);
        model_hi = 32'h0000_1234;
        WriteHI  = 1'b0;
        check("mthi", 128'({HI_Out, LO_Out}), 128'({model_hi, model_lo}));
        WriteHI = 1'b1;
        WriteLO = 1'b1;
        RS_In   = 32'hA5A5_0F0F;
        @(negedge Clock);
        model_hi = 32'hA5A5_0F0F;
        model_lo = 32'hA5A5_0F0F;
        WriteHI  = 1'b0;
        WriteLO  = 1'b0;
        check("mthi_mtlo", 128'({HI_Out, LO_Out}), 128'({model_hi, model_lo}));

        // Flushed Start and writes have no effect
        Flush   = 1'b1;
        Start   = 1'b1;
        Op      = 2'b11;
        RS_In   = 32'h0BAD_0BAD;
        RT_In   = 32'd3;
        WriteHI = 1'b1;
        WriteLO = 1'b1;
        @(negedge Clock);
        Flush   = 1'b0;
        Start   = 1'b0;
        WriteHI = 1'b0;
        WriteLO = 1'b0;
        check("flush_ignored", 128'({Busy, Done, Stall, HI_Out, LO_Out}),
              128'({1'b0, 1'b0, 1'b0, model_hi, model_lo}));
        idle_check(3);

        // Directed arithmetic cases with hand-derived results
        foreach (dir_tab[k]) begin
            issue(dir_tab[k].op, dir_tab[k].rs, dir_tab[k].rt);
            wait_op(1'b0, 1'b0, 2'b00, '0, '0);
            check($sformatf("directed_%0d", k), 128'({HI_Out, LO_Out}),
                  128'({dir_tab[k].hi, dir_tab[k].lo}));
        end

        // Start wins over mthi/mtlo in the same cycle
        WriteHI = 1'b1;
        WriteLO = 1'b1;
        issue(2'b00, 32'd9, 32'd9);
        wait_op(1'b1, 1'b0, 2'b00, '0, '0);
        check("start_priority", 128'({HI_Out, LO_Out}), 128'({32'd0, 32'd81}));

        // Second op and ReadHiLo held while busy, accepted only once idle
        issue(2'b11, 32'd1000, 32'd9);
        wait_op(1'b0, 1'b1, 2'b00, 32'd12345, 32'hFFFF_0000);
        check("held_first_result", 128'({HI_Out, LO_Out}), 128'({32'd1, 32'd111}));
        wait_op(1'b0, 1'b0, 2'b00, '0, '0);
        idle_check(2);

        // Random ops, including divide-by-zero and signed overflow corners
        for (int n = 0; n < 40; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_rs = $urandom;
            r_rt = $urandom;
            case ($urandom_range(0, 7))
                0: r_rt = '0;
                1: begin r_rs = 32'h8000_0000; r_rt = 32'hFFFF_FFFF; end
                2: r_rt = 32'($urandom_range(1, 20));
                3: r_rs = -32'($urandom_range(0, 1000));
                default: ;
            endcase
            issue(r_op, r_rs, r_rt);
            wait_op(1'b1, 1'b0, 2'b00, '0, '0);
            if ($urandom_range(0, 3) == 0) idle_check(1);
        end

        // Reset in the middle of RUN aborts without a Done pulse
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (11) @(negedge Clock);
        Start = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        Reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;
        exp_q.delete();
        check("reset_abort", 128'({Busy, Done, Stall, HI_Out, LO_Out}), 128'(0));
        idle_check(40);

        // Unit recovers after the abort
        issue(2'b10, 32'hFFFF_FF9C, 32'd7);
        wait_op(1'b1, 1'b0, 2'b00, '0, '0);
        check("after_reset_op", 128'({HI_Out, LO_Out}), 128'({32'hFFFF_FFFE, 32'hFFFF_FFF2}));
        idle_check(2);

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
